seq_csla_multiplier: RTL

SEQ_CSLA_MULTIPLIER -- requirements
Module: seq_csla_multiplier

---
 rtl/seq_csla_multiplier.sv | 118 +++++++++++
 1 files changed

// File: rtl/seq_csla_multiplier.sv
// Sequential shift-add multiplier: one partial product per cycle through a single
// carry-select adder that can run exact or with an approximate low block.

module param_csla #(
  parameter int W      = 8,
  parameter int APPROX = 0,
  parameter int BLK    = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int NB = (W + BLK - 1) / BLK;

  logic [NB:0] c;
  assign c[0] = cin;
  assign cout = c[NB];

  for (genvar i = 0; i < NB; i++) begin : g_blk
    localparam int LO = i * BLK;
    localparam int BW = (W - LO < BLK) ? (W - LO) : BLK;
    if (APPROX != 0 && i == 0 && NB > 1) begin : g_apx
      // Lower block is an OR-adder; its carry is guessed from the top bit pair only.
      assign sum[LO +: BW] = a[LO +: BW] | b[LO +: BW] | {{(BW-1){1'b0}}, c[i]};
      assign c[i+1]        = a[LO+BW-1] & b[LO+BW-1];
    end else begin : g_sel
      logic [BW:0] s0, s1;
      assign s0 = {1'b0, a[LO +: BW]} + {1'b0, b[LO +: BW]};
      assign s1 = {1'b0, a[LO +: BW]} + {1'b0, b[LO +: BW]} + {{BW{1'b0}}, 1'b1};
      assign {c[i+1], sum[LO +: BW]} = c[i] ? s1 : s0;
    end
  end
endmodule

module seq_csla_multiplier #(
  parameter int WIDTH  = 8,
  parameter int APPROX = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               in_ready,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               cg_en
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand, hi, lo, sum;
  logic             cout_reg, cout;
  logic [CW-1:0]    cnt;
  logic             cout_n;
  logic [WIDTH-1:0] hi_n, lo_n;

  param_csla #(.W(WIDTH), .APPROX(APPROX)) u_add (
    .a(hi), .b(mcand), .cin(1'b0), .sum(sum), .cout(cout)
  );

  // Capture-then-shift of {cout_reg, hi, lo}; the vacated top bit is always zero.
  always_comb begin
    if (lo[0]) {cout_n, hi_n, lo_n} = {1'b0, cout, sum, lo[WIDTH-1:1]};
    else       {cout_n, hi_n, lo_n} = {1'b0, cout_reg, hi, lo[WIDTH-1:1]};
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign cg_en     = (state == RUN) && lo[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mcand    <= '0;
      hi       <= '0;
      lo       <= '0;
      cout_reg <= 1'b0;
      cnt      <= '0;
      product  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (a == '0 || b == '0) begin
            product <= '0;
            state   <= DONE;
          end else begin
            mcand    <= a;
            hi       <= '0;
            lo       <= b;
            cout_reg <= 1'b0;
            cnt      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          hi       <= hi_n;
          lo       <= lo_n;
          cout_reg <= cout_n;
          cnt      <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            product <= {hi_n, lo_n};
            state   <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
